// File: rtl/ultrasonic_pkg.sv
// ultrasonic_pkg: state encodings, default 50 MHz timing and the echo width type.
package ultrasonic_pkg;
  localparam logic [2:0] ST_IDLE  = 3'd0;
  localparam logic [2:0] ST_TRIG  = 3'd1;
  localparam logic [2:0] ST_BURST = 3'd2;
  localparam logic [2:0] ST_ECHO  = 3'd3;
  localparam logic [2:0] ST_HOLD  = 3'd4;
  localparam int unsigned DEF_TRIG_MIN_CYCLES = 500;
  localparam int unsigned DEF_BURST_CYCLES    = 10000;
  localparam int unsigned DEF_CYCLES_PER_CM   = 2900;
  localparam int unsigned DEF_MIN_CM          = 2;
  localparam int unsigned DEF_MAX_CM          = 400;
  localparam int unsigned DEF_TIMEOUT_CYCLES  = 1900000;
  localparam int unsigned DEF_HOLDOFF_CYCLES  = 100000;
  typedef logic [20:0] width_t;
endpackage

// File: rtl/sync_edge_detector.sv
// sync_edge_detector: 2-FF synchronizer with registered rise/fall pulses aligned to q.
module sync_edge_detector (
  input  logic clk,
  input  logic rst_n,
  input  logic d,
  output logic q,
  output logic rise,
  output logic fall
);
  logic s1_q, s1_d, s2_q, s2_d, rise_q, rise_d, fall_q, fall_d;
  always_comb begin
    s1_d   = d;
    s2_d   = s1_q;
    rise_d = s1_q & ~s2_q;
    fall_d = ~s1_q & s2_q;
  end
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      s1_q   <= 1'b0;
      s2_q   <= 1'b0;
      rise_q <= 1'b0;
      fall_q <= 1'b0;
    end else begin
      s1_q   <= s1_d;
      s2_q   <= s2_d;
      rise_q <= rise_d;
      fall_q <= fall_d;
    end
  end
  assign q    = s2_q;
  assign rise = rise_q;
  assign fall = fall_q;
endmodule

// File: rtl/ultrasonic_echo_responder.sv
// ultrasonic_echo_responder: HC-SR04-style sensor model; echo width encodes the latched distance.
module ultrasonic_echo_responder
  import ultrasonic_pkg::*;
#(
  parameter int unsigned TRIG_MIN_CYCLES = DEF_TRIG_MIN_CYCLES,
  parameter int unsigned BURST_CYCLES    = DEF_BURST_CYCLES,
  parameter int unsigned CYCLES_PER_CM   = DEF_CYCLES_PER_CM,
  parameter int unsigned MIN_CM          = DEF_MIN_CM,
  parameter int unsigned MAX_CM          = DEF_MAX_CM,
  parameter int unsigned TIMEOUT_CYCLES  = DEF_TIMEOUT_CYCLES,
  parameter int unsigned HOLDOFF_CYCLES  = DEF_HOLDOFF_CYCLES
) (
  input  logic       clock,
  input  logic       reset,
  input  logic       enable,
  input  logic       trigger,
  input  logic [8:0] distancia_cm,
  output logic       echo,
  output logic       busy,
  output logic [7:0] contagem,
  output logic [2:0] db_estado
);
  localparam width_t     ONE      = width_t'(1);
  localparam width_t     TRIG_MIN = width_t'(TRIG_MIN_CYCLES);
  localparam width_t     BURST    = width_t'(BURST_CYCLES);
  localparam width_t     HOLDOFF  = width_t'(HOLDOFF_CYCLES);
  localparam width_t     CPC      = width_t'(CYCLES_PER_CM);
  localparam width_t     W_MIN    = width_t'(MIN_CM * CYCLES_PER_CM);
  localparam width_t     W_TMO    = width_t'(TIMEOUT_CYCLES);
  localparam logic [8:0] D_MIN    = 9'(MIN_CM);
  localparam logic [8:0] D_MAX    = 9'(MAX_CM);
  logic       trig_s, trig_rise, trig_fall;
  logic [2:0] state_q, state_d;
  width_t     cnt_q, cnt_d, width_q, width_d, w_calc;
  logic [8:0] dist_q, dist_d;
  logic       echo_q, echo_d, busy_q, busy_d;
  logic [7:0] cont_q, cont_d;
  sync_edge_detector u_sync (
    .clk  (clock),
    .rst_n(reset),
    .d    (trigger),
    .q    (trig_s),
    .rise (trig_rise),
    .fall (trig_fall)
  );
  // 511 * CYCLES_PER_CM stays below 2^21, so the 21-bit product cannot overflow
  assign w_calc = (dist_q < D_MIN) ? W_MIN : (dist_q > D_MAX) ? W_TMO : width_t'(dist_q) * CPC;
  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    dist_d  = dist_q;
    echo_d  = echo_q;
    cont_d  = cont_q;
    width_d = (state_q == ST_BURST) ? w_calc : width_q;
    case (state_q)
      ST_IDLE: if (trig_rise && enable) begin
        state_d = ST_TRIG;
        cnt_d   = ONE;
      end
      ST_TRIG: if (trig_fall) begin
        state_d = (cnt_q >= TRIG_MIN) ? ST_BURST : ST_IDLE;
        dist_d  = (cnt_q >= TRIG_MIN) ? distancia_cm : dist_q;
        cnt_d   = ONE;
      end else if (trig_s && cnt_q != '1) cnt_d = cnt_q + ONE;
      ST_BURST: if (cnt_q == BURST) begin
        state_d = ST_ECHO;
        cnt_d   = ONE;
        echo_d  = 1'b1;
      end else cnt_d = cnt_q + ONE;
      ST_ECHO: if (cnt_q == width_q) begin
        state_d = ST_HOLD;
        cnt_d   = ONE;
        echo_d  = 1'b0;
        cont_d  = cont_q + 8'd1;
      end else cnt_d = cnt_q + ONE;
      ST_HOLD: if (cnt_q == HOLDOFF) state_d = ST_IDLE;
      else cnt_d = cnt_q + ONE;
      default: state_d = ST_IDLE;
    endcase
    busy_d = (state_d != ST_IDLE);
  end
  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      state_q <= ST_IDLE;
      cnt_q   <= '0;
      dist_q  <= '0;
      width_q <= '0;
      echo_q  <= 1'b0;
      busy_q  <= 1'b0;
      cont_q  <= '0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      dist_q  <= dist_d;
      width_q <= width_d;
      echo_q  <= echo_d;
      busy_q  <= busy_d;
      cont_q  <= cont_d;
    end
  end
  assign echo      = echo_q;
  assign busy      = busy_q;
  assign contagem  = cont_q;
  assign db_estado = state_q;
endmodule

// File: tb/tb_ultrasonic_echo_responder.sv
// tb_ultrasonic_echo_responder: directed scenarios with small timing parameters.
module tb_ultrasonic_echo_responder;
  logic       clock = 1'b0;
  logic       reset = 1'b0;
  logic       enable = 1'b1;
  logic       trigger = 1'b0;
  logic [8:0] distancia_cm = '0;
  logic       echo, busy;
  logic [7:0] contagem;
  logic [2:0] db_estado;
  int checks = 0;
  int errors = 0;

  ultrasonic_echo_responder #(
    .TRIG_MIN_CYCLES(5), .BURST_CYCLES(10), .CYCLES_PER_CM(4), .MIN_CM(2),
    .MAX_CM(400), .TIMEOUT_CYCLES(2000), .HOLDOFF_CYCLES(20)
  ) dut (
    .clock(clock), .reset(reset), .enable(enable), .trigger(trigger),
    .distancia_cm(distancia_cm), .echo(echo), .busy(busy),
    .contagem(contagem), .db_estado(db_estado)
  );

  always #5 clock = ~clock;

  initial begin
    #3000000;
    $display("FAIL watchdog expired");
    $fatal(1, "watchdog");
  end

  task automatic step(input int n);
    repeat (n) begin
      @(posedge clock);
      #1;
    end
  endtask

  task automatic pulse(input int n);
    trigger = 1'b1;
    step(n);
    trigger = 1'b0;
  endtask

  task automatic wait_echo(output int n);
    n = 0;
    while (echo !== 1'b1 && n < 200) begin
      step(1);
      n++;
    end
  endtask

  task automatic measure(input logic [8:0] d, input int tcyc, output int bd, output int w,
                         output int hd, output logic [7:0] cf);
    int n;
    distancia_cm = d;
    pulse(tcyc);
    n = 0;
    while (db_estado !== 3'd2 && n < 100) begin
      step(1);
      n++;
    end
    bd = 0;
    while (echo !== 1'b1 && bd < 100) begin
      step(1);
      bd++;
    end
    w = 0;
    while (echo === 1'b1 && w < 5000) begin
      step(1);
      w++;
    end
    cf = contagem;
    hd = 0;
    while (busy === 1'b1 && hd < 100) begin
      step(1);
      hd++;
    end
  endtask

  task automatic test_reset;
    step(3);
    if (echo !== 1'b0) begin errors++; $display("FAIL reset_echo got %b want 0", echo); end
    checks++;
    if (busy !== 1'b0) begin errors++; $display("FAIL reset_busy got %b want 0", busy); end
    checks++;
    if (contagem !== 8'd0) begin errors++; $display("FAIL reset_cont got %0d want 0", contagem); end
    checks++;
    if (db_estado !== 3'd0) begin errors++; $display("FAIL reset_state got %0d want 0", db_estado); end
    checks++;
    reset = 1'b1;
    step(2);
  endtask

  task automatic test_nominal;
    int bd, w, hd;
    logic [7:0] cf;
    measure(9'd25, 8, bd, w, hd, cf);
    if (bd !== 10) begin errors++; $display("FAIL nom_burst got %0d want 10", bd); end
    checks++;
    if (w !== 100) begin errors++; $display("FAIL nom_width got %0d want 100", w); end
    checks++;
    if (cf !== 8'd1) begin errors++; $display("FAIL nom_cont got %0d want 1", cf); end
    checks++;
    if (hd !== 20) begin errors++; $display("FAIL nom_hold got %0d want 20", hd); end
    checks++;
  endtask

  task automatic test_runt;
    logic saw_busy, saw_burst;
    for (int len = 3; len <= 4; len++) begin
      saw_busy = 1'b0;
      saw_burst = 1'b0;
      distancia_cm = 9'd25;
      trigger = 1'b1;
      for (int i = 0; i < len; i++) begin
        step(1);
        saw_busy |= busy;
      end
      trigger = 1'b0;
      for (int i = 0; i < 40; i++) begin
        step(1);
        saw_busy |= busy;
        saw_burst |= echo | (db_estado == 3'd2);
      end
      if (saw_busy !== 1'b1) begin errors++; $display("FAIL runt%0d_busy got %b want 1", len, saw_busy); end
      checks++;
      if (saw_burst !== 1'b0) begin errors++; $display("FAIL runt%0d_burst got %b want 0", len, saw_burst); end
      checks++;
      if (db_estado !== 3'd0 || busy !== 1'b0) begin
        errors++; $display("FAIL runt%0d_idle got state %0d busy %b want 0 0", len, db_estado, busy);
      end
      checks++;
      if (contagem !== 8'd1) begin errors++; $display("FAIL runt%0d_cont got %0d want 1", len, contagem); end
      checks++;
    end
  endtask

  task automatic test_trig_min;
    int bd, w, hd;
    logic [7:0] cf;
    measure(9'd25, 5, bd, w, hd, cf);
    if (w !== 100) begin errors++; $display("FAIL tmin_width got %0d want 100", w); end
    checks++;
    if (cf !== 8'd2) begin errors++; $display("FAIL tmin_cont got %0d want 2", cf); end
    checks++;
  endtask

  task automatic test_clamp;
    logic [8:0] ds [6] = '{9'd0, 9'd1, 9'd2, 9'd401, 9'd400, 9'd511};
    int         ws [6] = '{8, 8, 8, 2000, 1600, 2000};
    int bd, w, hd;
    logic [7:0] cf;
    for (int i = 0; i < 6; i++) begin
      measure(ds[i], 8, bd, w, hd, cf);
      if (w !== ws[i]) begin errors++; $display("FAIL clamp_d%0d got %0d want %0d", ds[i], w, ws[i]); end
      checks++;
    end
    if (contagem !== 8'd8) begin errors++; $display("FAIL clamp_cont got %0d want 8", contagem); end
    checks++;
  endtask

  task automatic test_lockout;
    int n, w, bd, hd;
    logic saw;
    logic [7:0] cf;
    distancia_cm = 9'd25;
    pulse(8);
    wait_echo(n);
    step(20);
    pulse(8);
    distancia_cm = 9'd10;
    w = 28;
    while (echo === 1'b1 && w < 5000) begin
      step(1);
      w++;
    end
    if (w !== 100) begin errors++; $display("FAIL lock_width got %0d want 100", w); end
    checks++;
    saw = 1'b0;
    for (int i = 0; i < 80; i++) begin
      step(1);
      saw |= echo | (db_estado == 3'd2);
    end
    if (saw !== 1'b0) begin errors++; $display("FAIL lock_second got %b want 0", saw); end
    checks++;
    measure(9'd10, 8, bd, w, hd, cf);
    if (w !== 40) begin errors++; $display("FAIL lock_new got %0d want 40", w); end
    checks++;
    if (cf !== 8'd10) begin errors++; $display("FAIL lock_cont got %0d want 10", cf); end
    checks++;
  endtask

  task automatic test_reset_mid_echo;
    int n, bd, w, hd;
    logic [7:0] cf;
    distancia_cm = 9'd25;
    pulse(8);
    wait_echo(n);
    step(50);
    reset = 1'b0;
    #1;
    if (echo !== 1'b0) begin errors++; $display("FAIL rme_echo got %b want 0", echo); end
    checks++;
    if (busy !== 1'b0) begin errors++; $display("FAIL rme_busy got %b want 0", busy); end
    checks++;
    if (contagem !== 8'd0) begin errors++; $display("FAIL rme_cont got %0d want 0", contagem); end
    checks++;
    if (db_estado !== 3'd0) begin errors++; $display("FAIL rme_state got %0d want 0", db_estado); end
    checks++;
    step(2);
    reset = 1'b1;
    step(2);
    measure(9'd25, 8, bd, w, hd, cf);
    if (bd !== 10 || w !== 100 || hd !== 20) begin
      errors++; $display("FAIL rme_after got burst %0d width %0d hold %0d want 10 100 20", bd, w, hd);
    end
    checks++;
    if (cf !== 8'd1) begin errors++; $display("FAIL rme_after_cont got %0d want 1", cf); end
    checks++;
  endtask

  task automatic test_wrap;
    int bd, w, hd;
    logic [7:0] cf;
    reset = 1'b0;
    step(2);
    reset = 1'b1;
    step(2);
    for (int i = 0; i < 255; i++) measure(9'd0, 5, bd, w, hd, cf);
    if (contagem !== 8'd255) begin errors++; $display("FAIL wrap_255 got %0d want 255", contagem); end
    checks++;
    measure(9'd0, 5, bd, w, hd, cf);
    if (cf !== 8'd0) begin errors++; $display("FAIL wrap_0 got %0d want 0", cf); end
    checks++;
  endtask

  task automatic test_enable;
    int n, w;
    logic saw;
    enable = 1'b0;
    distancia_cm = 9'd25;
    saw = 1'b0;
    trigger = 1'b1;
    for (int i = 0; i < 8; i++) begin
      step(1);
      saw |= busy;
    end
    trigger = 1'b0;
    for (int i = 0; i < 60; i++) begin
      step(1);
      saw |= busy | echo | (db_estado != 3'd0);
    end
    if (saw !== 1'b0) begin errors++; $display("FAIL en_ignored got %b want 0", saw); end
    checks++;
    enable = 1'b1;
    distancia_cm = 9'd3;
    pulse(8);
    n = 0;
    while (db_estado !== 3'd2 && n < 100) begin
      step(1);
      n++;
    end
    enable = 1'b0;
    wait_echo(n);
    w = 0;
    while (echo === 1'b1 && w < 5000) begin
      step(1);
      w++;
    end
    if (w !== 12) begin errors++; $display("FAIL en_complete got %0d want 12", w); end
    checks++;
    if (contagem !== 8'd1) begin errors++; $display("FAIL en_cont got %0d want 1", contagem); end
    checks++;
    enable = 1'b1;
  endtask

  initial begin
    test_reset;
    test_nominal;
    test_runt;
    test_trig_min;
    test_clamp;
    test_lockout;
    test_reset_mid_echo;
    test_wrap;
    test_enable;
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule
